// File: rtl/stack_ctrl.sv
// Round-robin arbiter and sequencer between two requesters and the hardware stack.
// Define STACK_CTRL_HWM_EN to add the high-water-mark output and its clear input.
module stack_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int SP_WIDTH   = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iReq0,
    input  logic                  iReq1,
    input  logic                  iPop0,
    input  logic                  iPop1,
    input  logic [DATA_WIDTH-1:0] iData0,
    input  logic [DATA_WIDTH-1:0] iData1,
    input  logic                  iSetSP,
    input  logic [SP_WIDTH-1:0]   iSPValue,
    output logic                  oAck0,
    output logic                  oAck1,
    output logic [DATA_WIDTH-1:0] oRdData,
    output logic                  oOvf,
    output logic                  oUnf,
    output logic                  oStkWrite,
    output logic                  oStkRead,
    output logic                  oStkSetSP,
    output logic [DATA_WIDTH-1:0] oStkData,
    output logic [SP_WIDTH-1:0]   oStkSPIn,
    input  logic [DATA_WIDTH-1:0] iStkData,
    input  logic [SP_WIDTH-1:0]   iStkSP
`ifdef STACK_CTRL_HWM_EN
    ,
    input  logic                  iHwmClr,
    output logic [SP_WIDTH-1:0]   oHighWater
`endif
);

    localparam logic [SP_WIDTH-1:0] SP_TOP = SP_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_State;
    logic                  r_Port;
    logic                  r_Pop;
    logic                  r_SetOp;
    logic                  r_ErrFlag;
    logic                  r_LastGnt;
    logic                  r_Ack0;
    logic                  r_Ack1;
    logic                  r_Ovf;
    logic                  r_Unf;
    logic                  r_StkWrite;
    logic                  r_StkRead;
    logic                  r_StkSetSP;
    logic [DATA_WIDTH-1:0] r_RdData;
    logic [DATA_WIDTH-1:0] r_StkData;
    logic [SP_WIDTH-1:0]   r_StkSPIn;
`ifdef STACK_CTRL_HWM_EN
    logic [SP_WIDTH-1:0]   r_Hwm;
`endif

    logic                  w_AnyReq;
    logic                  w_Gnt1;
    logic                  w_Pop;
    logic [DATA_WIDTH-1:0] w_Data;

    // On a tie, the port that did not win last time gets the grant.
    always_comb begin
        w_AnyReq = iReq0 | iReq1;
        w_Gnt1   = iReq1 & (~iReq0 | ~r_LastGnt);
        w_Pop    = w_Gnt1 ? iPop1 : iPop0;
        w_Data   = w_Gnt1 ? iData1 : iData0;
    end

    // Strobe/error decisions are made when leaving IDLE; only this block moves SP.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_State    <= IDLE;
            r_Port     <= 1'b0;
            r_Pop      <= 1'b0;
            r_SetOp    <= 1'b0;
            r_ErrFlag  <= 1'b0;
            r_LastGnt  <= 1'b1;
            r_Ack0     <= 1'b0;
            r_Ack1     <= 1'b0;
            r_Ovf      <= 1'b0;
            r_Unf      <= 1'b0;
            r_StkWrite <= 1'b0;
            r_StkRead  <= 1'b0;
            r_StkSetSP <= 1'b0;
            r_RdData   <= '0;
            r_StkData  <= '0;
            r_StkSPIn  <= '0;
`ifdef STACK_CTRL_HWM_EN
            r_Hwm      <= '0;
`endif
        end else begin
            r_Ack0     <= 1'b0;
            r_Ack1     <= 1'b0;
            r_Ovf      <= 1'b0;
            r_Unf      <= 1'b0;
            r_StkWrite <= 1'b0;
            r_StkRead  <= 1'b0;
            r_StkSetSP <= 1'b0;
            case (r_State)
                IDLE: begin
                    if (iSetSP) begin
                        r_SetOp    <= 1'b1;
                        r_StkSetSP <= 1'b1;
                        r_StkSPIn  <= iSPValue;
                        r_State    <= EXEC;
                    end else if (w_AnyReq) begin
                        r_SetOp   <= 1'b0;
                        r_Port    <= w_Gnt1;
                        r_LastGnt <= w_Gnt1;
                        r_Pop     <= w_Pop;
                        if (w_Pop) begin
                            r_StkRead <= (iStkSP != '0);
                            r_ErrFlag <= (iStkSP == '0);
                        end else begin
                            r_StkWrite <= (iStkSP != SP_TOP);
                            r_StkData  <= w_Data;
                            r_ErrFlag  <= (iStkSP == SP_TOP);
                        end
                        r_State <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_SetOp) begin
                        r_State <= IDLE;
                    end else begin
                        r_Ack0 <= ~r_Port;
                        r_Ack1 <= r_Port;
                        r_Ovf  <= r_ErrFlag & ~r_Pop;
                        r_Unf  <= r_ErrFlag & r_Pop;
                        if (r_Pop) begin
                            r_RdData <= r_ErrFlag ? '0 : iStkData;
                        end
                        r_State <= DONE;
                    end
                end
                DONE: begin
`ifdef STACK_CTRL_HWM_EN
                    if (!r_Pop && !r_ErrFlag && (iStkSP > r_Hwm)) begin
                        r_Hwm <= iStkSP;
                    end
`endif
                    r_State <= IDLE;
                end
                default: r_State <= IDLE;
            endcase
`ifdef STACK_CTRL_HWM_EN
            if (iHwmClr) begin
                r_Hwm <= '0;
            end
`endif
        end
    end

    assign oAck0     = r_Ack0;
    assign oAck1     = r_Ack1;
    assign oRdData   = r_RdData;
    assign oOvf      = r_Ovf;
    assign oUnf      = r_Unf;
    assign oStkWrite = r_StkWrite;
    assign oStkRead  = r_StkRead;
    assign oStkSetSP = r_StkSetSP;
    assign oStkData  = r_StkData;
    assign oStkSPIn  = r_StkSPIn;
`ifdef STACK_CTRL_HWM_EN
    assign oHighWater = r_Hwm;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: behavioural stack, reference SP model and an ack scoreboard.
module tb_stack_ctrl;

    localparam int DW    = 16;
    localparam int SPW   = 6;
    localparam int DEPTH = 64;

    logic           Clock = 1'b0;
    logic           Reset = 1'b1;
    logic           iReq0 = 1'b0, iReq1 = 1'b0, iPop0 = 1'b0, iPop1 = 1'b0;
    logic [DW-1:0]  iData0 = '0, iData1 = '0;
    logic           iSetSP = 1'b0;
    logic [SPW-1:0] iSPValue = '0;
    logic           oAck0, oAck1, oOvf, oUnf, oStkWrite, oStkRead, oStkSetSP;
    logic [DW-1:0]  oRdData, oStkData, iStkData;
    logic [SPW-1:0] oStkSPIn, iStkSP;
`ifdef STACK_CTRL_HWM_EN
    logic           iHwmClr = 1'b0;
    logic [SPW-1:0] oHighWater;
`endif

    stack_ctrl #(.DATA_WIDTH(DW), .SP_WIDTH(SPW), .DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset),
        .iReq0(iReq0), .iReq1(iReq1), .iPop0(iPop0), .iPop1(iPop1),
        .iData0(iData0), .iData1(iData1), .iSetSP(iSetSP), .iSPValue(iSPValue),
        .oAck0(oAck0), .oAck1(oAck1), .oRdData(oRdData), .oOvf(oOvf), .oUnf(oUnf),
        .oStkWrite(oStkWrite), .oStkRead(oStkRead), .oStkSetSP(oStkSetSP),
        .oStkData(oStkData), .oStkSPIn(oStkSPIn), .iStkData(iStkData), .iStkSP(iStkSP)
`ifdef STACK_CTRL_HWM_EN
        , .iHwmClr(iHwmClr), .oHighWater(oHighWater)
`endif
    );

    always #5 Clock = ~Clock;

    // Behavioural stack: SP points at the next free slot, read data is the word at SP-1.
    logic [DW-1:0]  mem [DEPTH];
    logic [SPW-1:0] sp;
    always @(posedge Clock or posedge Reset) begin
        if (Reset) sp <= '0;
        else if (oStkSetSP) sp <= oStkSPIn;
        else if (oStkWrite) sp <= sp + 6'd1;
        else if (oStkRead) sp <= sp - 6'd1;
    end
    always @(posedge Clock) begin
        if (!Reset && oStkWrite) mem[sp] <= oStkData;
    end
    assign iStkSP   = sp;
    assign iStkData = mem[sp - 6'd1];

    typedef struct {
        logic          port;
        logic          ovf;
        logic          unf;
        logic          chk_rd;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t          exp_q[$];
    int            n_chk  = 0;
    int            n_pass = 0;
    int            ref_sp = 0;
    logic [DW-1:0] ref_mem [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: every ack is matched against the oldest expected result.
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset && (oAck0 || oAck1)) begin
            chk("ack_pending", 32'(exp_q.size() > 0), 32'd1);
            chk("ack_onehot", 32'(oAck0 & oAck1), 32'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ack_port", 32'(oAck1), 32'(e.port));
                chk("ovf", 32'(oOvf), 32'(e.ovf));
                chk("unf", 32'(oUnf), 32'(e.unf));
                if (e.chk_rd) chk("rd_data", 32'(oRdData), 32'(e.rd));
            end
        end
    end

    function automatic exp_t predict(input logic port, input logic pop, input logic [DW-1:0] data);
        exp_t e;
        e.port = port; e.ovf = 1'b0; e.unf = 1'b0; e.chk_rd = pop; e.rd = '0;
        if (pop) begin
            if (ref_sp == 0) e.unf = 1'b1;
            else begin ref_sp--; e.rd = ref_mem[ref_sp]; end
        end else begin
            if (ref_sp == DEPTH - 1) e.ovf = 1'b1;
            else begin ref_mem[ref_sp] = data; ref_sp++; end
        end
        return e;
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        ref_sp = 0;
        repeat (2) @(negedge Clock);
        chk("rst_outs", {oAck0, oAck1, oOvf, oUnf, oStkWrite, oStkRead, oStkSetSP}, 32'd0);
        chk("rst_data", {oRdData, oStkData}, 32'd0);
        chk("rst_spin", 32'(oStkSPIn), 32'd0);
        Reset = 1'b0;
    endtask

    // Called at a negedge with the FSM in IDLE; returns at a negedge with the FSM in IDLE.
    task automatic do_op(input logic port, input logic pop, input logic [DW-1:0] data);
        exp_t e;
        e = predict(port, pop, data);
        exp_q.push_back(e);
        if (port) begin iReq1 = 1'b1; iPop1 = pop; iData1 = data; end
        else      begin iReq0 = 1'b1; iPop0 = pop; iData0 = data; end
        @(negedge Clock);
        chk("strobe_wr", 32'(oStkWrite), 32'(!pop && !e.ovf));
        chk("strobe_rd", 32'(oStkRead), 32'(pop && !e.unf));
        if (!pop && !e.ovf) chk("stk_data", 32'(oStkData), 32'(data));
        @(negedge Clock);
        chk("ack_lat", 32'(port ? oAck1 : oAck0), 32'd1);
        iReq0 = 1'b0; iReq1 = 1'b0;
        @(negedge Clock);
    endtask

    initial begin
        int acks, last_cyc, first_cyc;
        logic [DW-1:0] tmp;

        // Push then pop on port 0
        do_reset();
        do_op(1'b0, 1'b0, 16'h1234);
        do_op(1'b0, 1'b1, 16'h0000);

        // Both ports held from reset: strict alternation, acks 3 cycles apart
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tmp = (i % 2 == 0) ? 16'hA0A0 : 16'hB1B1;
            exp_q.push_back(predict(1'(i % 2), 1'b0, tmp));
        end
        iData0 = 16'hA0A0; iData1 = 16'hB1B1; iPop0 = 1'b0; iPop1 = 1'b0;
        iReq0 = 1'b1; iReq1 = 1'b1;
        acks = 0; last_cyc = 0; first_cyc = 0;
        for (int c = 1; c <= 20 && acks < 4; c++) begin
            @(negedge Clock);
            if (oAck0 || oAck1) begin
                if (acks == 0) first_cyc = c;
                else chk("rr_spacing", 32'(c - last_cyc), 32'd3);
                last_cyc = c;
                acks++;
            end
        end
        chk("rr_ack_count", 32'(acks), 32'd4);
        chk("rr_first_ack", 32'(first_cyc), 32'd2);
        iReq0 = 1'b0; iReq1 = 1'b0;
        @(negedge Clock);
        chk("rr_sp", 32'(sp), 32'd4);
        do_op(1'b1, 1'b1, 16'h0000);

        // Pop on empty stack
        do_reset();
        do_op(1'b0, 1'b1, 16'h0000);

        // setSP together with a port 1 request: setSP first, no ack for it
        iSetSP = 1'b1; iSPValue = 6'd10;
        iReq1 = 1'b1; iPop1 = 1'b0; iData1 = 16'hBEEF;
        @(negedge Clock);
        iSetSP = 1'b0;
        chk("setsp_strobe", 32'(oStkSetSP), 32'd1);
        chk("setsp_value", 32'(oStkSPIn), 32'd10);
        chk("setsp_nowr", 32'(oStkWrite | oStkRead), 32'd0);
        @(negedge Clock);
        chk("setsp_noack", 32'(oAck0 | oAck1 | oOvf | oUnf), 32'd0);
        chk("setsp_sp", 32'(sp), 32'd10);
        ref_sp = 10;
        exp_q.push_back(predict(1'b1, 1'b0, 16'hBEEF));
        @(negedge Clock);
        chk("setsp_req_wr", 32'(oStkWrite), 32'd1);
        chk("setsp_req_data", 32'(oStkData), 32'h0000BEEF);
        @(negedge Clock);
        chk("setsp_req_ack", 32'(oAck1), 32'd1);
        iReq1 = 1'b0;
        @(negedge Clock);
        chk("setsp_push_sp", 32'(sp), 32'd11);

        // Fill to 63, then overflow
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) do_op(1'(i % 2), 1'b0, 16'(i * 3 + 1));
        chk("full_sp", 32'(sp), 32'd63);
        do_op(1'b0, 1'b0, 16'hDEAD);
        chk("ovf_sp", 32'(sp), 32'd63);
        do_op(1'b1, 1'b1, 16'h0000);

        // Reset while a push is in EXEC
        do_reset();
        iReq0 = 1'b1; iPop0 = 1'b0; iData0 = 16'h5555;
        @(negedge Clock);
        chk("exec_wr", 32'(oStkWrite), 32'd1);
        #2 Reset = 1'b1;
        #1 chk("abort_wr_drop", 32'(oStkWrite), 32'd0);
        iReq0 = 1'b0;
        ref_sp = 0;
        @(negedge Clock);
        Reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clock);
            chk("abort_noack", 32'(oAck0 | oAck1), 32'd0);
        end
        chk("abort_sp", 32'(sp), 32'd0);
        do_op(1'b0, 1'b0, 16'h7777);
        do_op(1'b0, 1'b1, 16'h0000);

`ifdef STACK_CTRL_HWM_EN
        do_reset();
        chk("hwm_rst", 32'(oHighWater), 32'd0);
        for (int i = 0; i < 5; i++) do_op(1'b0, 1'b0, 16'(i));
        chk("hwm_5", 32'(oHighWater), 32'd5);
        do_op(1'b0, 1'b1, 16'h0000);
        chk("hwm_after_pop", 32'(oHighWater), 32'd5);
        iHwmClr = 1'b1;
        @(negedge Clock);
        iHwmClr = 1'b0;
        chk("hwm_clr", 32'(oHighWater), 32'd0);
`endif

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
